// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default 640x480@60 timing constants shared by the sync generator
package video_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_HS_POL   = 1'b0;
  localparam bit VGA_VS_POL   = 1'b0;
  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_PIPE     = 2;
  localparam int VGA_CNT_W    = 10;
  localparam int VGA_FRAME_W  = 16;
endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis_counter: one timing axis (count, wrap event, active and sync decode)
module timing_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = 10
)(
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);
  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
    $error("timing_axis_counter: every interval must be at least 1");
  end
  if (TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("timing_axis_counter: total does not fit in CNT_W");
  end
  // wrap marks the enabled step that returns the count to 0
  assign wrap    = en && cnt == LAST;
  assign cnt_nxt = en ? (wrap ? '0 : cnt + 1'b1) : cnt;
  // count plus decode registered together so all three stay aligned
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= '0;
      active <= 1'b0;
      sync   <= ~POL;
    end else begin
      cnt    <= cnt_nxt;
      active <= cnt_nxt < ACT_END;
      sync   <= (cnt_nxt >= SYNC_LO && cnt_nxt < SYNC_HI) ? POL : ~POL;
    end
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: VGA sync, lookahead request coordinates, delayed display coordinates and frame pacing
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = VGA_HS_POL,
  parameter bit VS_POL   = VGA_VS_POL,
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int PIPE     = VGA_PIPE,
  parameter int CNT_W    = VGA_CNT_W,
  parameter int FRAME_W  = VGA_FRAME_W
)(
  input  logic               clk,
  input  logic               clrn,
  output logic               pix_ce,
  output logic [CNT_W-1:0]   req_col,
  output logic [CNT_W-1:0]   req_row,
  output logic               req_valid,
  output logic               hsync,
  output logic               vsync,
  output logic               in_screen,
  output logic [CNT_W-1:0]   col,
  output logic [CNT_W-1:0]   row,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] VB_ROW = CNT_W'(V_ACTIVE);
  localparam int SW = 3 + 2 * CNT_W;
  localparam logic [SW-1:0] IDLE = {~HS_POL, ~VS_POL, 1'b0, {2 * CNT_W{1'b0}}};
  if (CLK_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: CLK_DIV must be >= 1");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
    $error("video_timing_gen: PIPE must be 0..7");
  end
  logic [DW-1:0]    div_cnt, div_nxt;
  logic             pce_nxt, fs_nxt, vb_nxt, first_frame;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic [SW-1:0]    raw, tail;
  timing_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .clrn(clrn), .en(pix_ce), .cnt(req_col), .cnt_nxt(h_nxt),
    .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );
  timing_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .clrn(clrn), .en(pix_ce && h_wrap), .cnt(req_row), .cnt_nxt(v_nxt),
    .wrap(v_wrap), .active(v_act), .sync(v_sync)
  );
  assign req_valid = h_act && v_act;
  assign raw = {h_sync, v_sync, req_valid, req_col, req_row};
  // pulses are registered one clk early so they coincide with the pix_ce they describe;
  // the counters only move on a pix_ce, so (0,0) next cycle means a frame wrap now or already sitting at (0,0)
  always_comb begin
    div_nxt = div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
    pce_nxt = div_nxt == DIV_LAST;
    fs_nxt  = pce_nxt && (pix_ce ? v_wrap : (req_col == '0 && req_row == '0));
    vb_nxt  = pce_nxt && h_nxt == '0 && v_nxt == VB_ROW;
  end
  // divider, pulses and completed-frame counter; first frame after reset is not counted
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_cnt      <= '0;
      pix_ce       <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
      first_frame  <= 1'b1;
    end else begin
      div_cnt      <= div_nxt;
      pix_ce       <= pce_nxt;
      frame_start  <= fs_nxt;
      vblank_start <= vb_nxt;
      if (fs_nxt) begin
        first_frame <= 1'b0;
        if (!first_frame) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
  if (PIPE == 0) begin : g_nopipe
    assign tail = raw;
  end else begin : g_pipe
    logic [SW-1:0] stage [PIPE];
    // display delay line, advanced one pixel per pix_ce
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        for (int i = 0; i < PIPE; i++) stage[i] <= IDLE;
      end else if (pix_ce) begin
        stage[0] <= raw;
        for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
      end
    end
    assign tail = stage[PIPE-1];
  end
  assign {hsync, vsync, in_screen, col, row} = tail;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: table vectors, reset sequences and randomized resets against an arithmetic timing model
module tb_video_timing_gen;
  typedef struct packed {
    logic        pce;
    logic [9:0]  rc;
    logic [9:0]  rr;
    logic        rv;
    logic        hs;
    logic        vs;
    logic        ins;
    logic [9:0]  c;
    logic [9:0]  r;
    logic        fs;
    logic        vb;
    logic [15:0] fc;
  } obs_t;
  typedef struct {
    int inst; int t;
    logic pce, fs, vb, hs, vs, ins;
    logic [2:0] fc;
    logic [9:0] rc, c;
  } vec_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int t = 0;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;

  logic a_pce, a_rv, a_hs, a_vs, a_ins, a_fs, a_vb;
  logic [9:0] a_rc, a_rr, a_c, a_r;
  logic [15:0] a_fc;
  logic b_pce, b_rv, b_hs, b_vs, b_ins, b_fs, b_vb;
  logic [3:0] b_rc, b_rr, b_c, b_r;
  logic [1:0] b_fc;
  logic c_pce, c_rv, c_hs, c_vs, c_ins, c_fs, c_vb;
  logic [3:0] c_rc, c_rr, c_c, c_r;
  logic [2:0] c_fc;
  obs_t a_obs, b_obs, c_obs;

  video_timing_gen ua (
    .clk(clk), .clrn(clrn), .pix_ce(a_pce), .req_col(a_rc), .req_row(a_rr), .req_valid(a_rv),
    .hsync(a_hs), .vsync(a_vs), .in_screen(a_ins), .col(a_c), .row(a_r),
    .frame_start(a_fs), .vblank_start(a_vb), .frame_cnt(a_fc)
  );
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .PIPE(1), .CNT_W(4), .FRAME_W(2)
  ) ub (
    .clk(clk), .clrn(clrn), .pix_ce(b_pce), .req_col(b_rc), .req_row(b_rr), .req_valid(b_rv),
    .hsync(b_hs), .vsync(b_vs), .in_screen(b_ins), .col(b_c), .row(b_r),
    .frame_start(b_fs), .vblank_start(b_vb), .frame_cnt(b_fc)
  );
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .PIPE(0), .CNT_W(4), .FRAME_W(3)
  ) uc (
    .clk(clk), .clrn(clrn), .pix_ce(c_pce), .req_col(c_rc), .req_row(c_rr), .req_valid(c_rv),
    .hsync(c_hs), .vsync(c_vs), .in_screen(c_ins), .col(c_c), .row(c_r),
    .frame_start(c_fs), .vblank_start(c_vb), .frame_cnt(c_fc)
  );

  assign a_obs = {a_pce, a_rc, a_rr, a_rv, a_hs, a_vs, a_ins, a_c, a_r, a_fs, a_vb, a_fc};
  assign b_obs = {b_pce, 6'd0, b_rc, 6'd0, b_rr, b_rv, b_hs, b_vs, b_ins, 6'd0, b_c, 6'd0, b_r,
                  b_fs, b_vb, 14'd0, b_fc};
  assign c_obs = {c_pce, 6'd0, c_rc, 6'd0, c_rr, c_rv, c_hs, c_vs, c_ins, 6'd0, c_c, 6'd0, c_r,
                  c_fs, c_vb, 13'd0, c_fc};

  // t = clk edges since clrn release; pixel index n = pix_ce events before cycle t
  function automatic obs_t model(int tt, int d, int p, int ha, int hf, int hw, int hb,
                                 int va, int vf, int vw, int vb, bit hp, bit vp, int fw);
    obs_t o;
    int ht, vt, fr, n, m, h, v, k;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    fr = ht * vt;
    o = '0;
    o.hs = !hp;
    o.vs = !vp;
    if (tt == 0) return o;
    o.pce = (tt % d) == d - 1;
    n = tt / d - (d == 1 ? 1 : 0);
    o.rc = 10'(n % ht);
    o.rr = 10'((n / ht) % vt);
    o.rv = (n % ht < ha) && ((n / ht) % vt < va);
    m = n - p;
    if (m >= 0) begin
      h = m % ht;
      v = (m / ht) % vt;
      o.hs = (h >= ha + hf && h < ha + hf + hw) ? hp : !hp;
      o.vs = (v >= va + vf && v < va + vf + vw) ? vp : !vp;
      o.ins = h < ha && v < va;
      o.c = 10'(h);
      o.r = 10'(v);
    end
    o.fs = o.pce && n % fr == 0;
    o.vb = o.pce && n % fr == va * ht;
    k = n + (o.pce ? 1 : 0);
    k = k == 0 ? 0 : (k - 1) / fr;
    o.fc = 16'(k % (1 << fw));
    return o;
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
  endtask

  task automatic check_all();
    cmp("A", 64'(a_obs), 64'(model(t, 4, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16)));
    cmp("B", 64'(b_obs), 64'(model(t, 1, 1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 2)));
    cmp("C", 64'(c_obs), 64'(model(t, 3, 0, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, 3)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (clrn) t++;
    #2;
  endtask

  function automatic vec_t mk(int inst, int tt, logic pce, logic fs, logic vb, logic hs, logic vs,
                              logic ins, int fc, int rc, int c);
    vec_t e;
    e.inst = inst; e.t = tt; e.pce = pce; e.fs = fs; e.vb = vb; e.hs = hs; e.vs = vs; e.ins = ins;
    e.fc = 3'(fc); e.rc = 10'(rc); e.c = 10'(c);
    return e;
  endfunction

  initial begin
    vec_t tbl[$];
    obs_t s;
    int g;
    // inst 0 = defaults (CLK_DIV 4, PIPE 2, active-low syncs); inst 1 = small, CLK_DIV 1, PIPE 1, active-high
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 3, 1, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 7, 1, 0, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8, 0, 0, 0, 1, 1, 1, 0, 2, 0));
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 1, 0, 8, 7));
    tbl.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 9, 8));
    tbl.push_back(mk(1, 11, 1, 0, 0, 1, 0, 0, 0, 10, 9));
    tbl.push_back(mk(1, 12, 1, 0, 0, 1, 0, 0, 0, 11, 10));
    tbl.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 11));
    tbl.push_back(mk(1, 14, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 49, 1, 0, 1, 0, 0, 0, 0, 0, 11));
    tbl.push_back(mk(1, 62, 1, 0, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 73, 1, 0, 0, 0, 1, 0, 0, 0, 11));
    tbl.push_back(mk(1, 74, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 85, 1, 1, 0, 0, 0, 0, 1, 0, 11));
    tbl.push_back(mk(1, 86, 1, 0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 169, 1, 1, 0, 0, 0, 0, 2, 0, 11));
    tbl.push_back(mk(1, 253, 1, 1, 0, 0, 0, 0, 3, 0, 11));
    tbl.push_back(mk(1, 337, 1, 1, 0, 0, 0, 0, 0, 0, 11));
    tbl.push_back(mk(1, 421, 1, 1, 0, 0, 0, 0, 1, 0, 11));
    tbl.push_back(mk(0, 2567, 1, 0, 0, 1, 1, 1, 0, 641, 639));
    tbl.push_back(mk(0, 2568, 0, 0, 0, 1, 1, 0, 0, 642, 640));
    tbl.push_back(mk(0, 2631, 1, 0, 0, 1, 1, 0, 0, 657, 655));
    tbl.push_back(mk(0, 2632, 0, 0, 0, 0, 1, 0, 0, 658, 656));
    tbl.push_back(mk(0, 3015, 1, 0, 0, 0, 1, 0, 0, 753, 751));
    tbl.push_back(mk(0, 3016, 0, 0, 0, 1, 1, 0, 0, 754, 752));
    tbl.push_back(mk(0, 5832, 0, 0, 0, 0, 1, 0, 0, 658, 656));
    repeat (3) tick();
    clrn = 1'b1;
    foreach (tbl[i]) begin
      g = 0;
      while (t < tbl[i].t && g < 10000) begin
        tick();
        g++;
      end
      s = tbl[i].inst == 0 ? a_obs : b_obs;
      cmp($sformatf("tbl%0d", i),
          64'({s.pce, s.fs, s.vb, s.hs, s.vs, s.ins, s.fc[2:0], s.rc, s.c}),
          64'({tbl[i].pce, tbl[i].fs, tbl[i].vb, tbl[i].hs, tbl[i].vs, tbl[i].ins, tbl[i].fc,
               tbl[i].rc, tbl[i].c}));
    end
    // mid-line asynchronous reset
    g = 0;
    while (a_rc != 10'd300 && g < 4000) begin
      tick();
      g++;
    end
    cmp("wait_col300", 64'(a_rc), 64'd300);
    clrn = 1'b0;
    t = 0;
    #1;
    check_all();
    repeat (3) begin
      tick();
      check_all();
    end
    clrn = 1'b1;
    check_all();
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_all();
      if (k == 1) cmp("rst_fs_early", 64'({a_pce, a_fs}), 64'd0);
    end
    cmp("rst_first_pix", 64'({a_pce, a_fs, a_rc, a_rr}), 64'({1'b1, 1'b1, 20'd0}));
    // long run with occasional random asynchronous resets
    for (int k = 0; k < 15000; k++) begin
      tick();
      check_all();
      if ($urandom_range(0, 2999) == 0) begin
        clrn = 1'b0;
        t = 0;
        #1;
        check_all();
        repeat ($urandom_range(1, 4)) begin
          tick();
          check_all();
        end
        clrn = 1'b1;
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync generator.
- Produces VGA hsync/vsync, an active-area flag and pixel coordinates from the system clock through an internal pixel clock-enable.
- Adds a lookahead pixel-request coordinate so the renderer can absorb ROM/pipeline latency.
- Adds frame/vblank tick pulses and a frame counter for game-logic pacing.
- Sits between the board clock and the renderer; replaces the divider tap plus sync block in the top level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CLK_DIV, 4, system clocks per pixel; must be >=1
- PIPE, 2, pixel-clock delay of the display outputs relative to the request outputs; 0..7
- CNT_W, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 16, frame counter width

Ports:
- clk, in, 1, system clock
- clrn, in, 1, asynchronous active-low reset
- pix_ce, out, 1, one-clk pixel enable, every CLK_DIV clocks
- req_col, out, CNT_W, lookahead column (undelayed)
- req_row, out, CNT_W, lookahead row (undelayed)
- req_valid, out, 1, lookahead coordinate is in the active area
- hsync, out, 1, horizontal sync (delayed PIPE)
- vsync, out, 1, vertical sync (delayed PIPE)
- in_screen, out, 1, active area (delayed PIPE)
- col, out, CNT_W, display column (delayed PIPE)
- row, out, CNT_W, display row (delayed PIPE)
- frame_start, out, 1, one-clk pulse at pixel (0,0)
- vblank_start, out, 1, one-clk pulse at first blank line
- frame_cnt, out, FRAME_W, completed-frame count, wraps

Behaviour:
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. All outputs are registered.
- Divider: div_cnt runs 0..CLK_DIV-1 and wraps. pix_ce=1 for the single clk where div_cnt==CLK_DIV-1. CLK_DIV=1 gives pix_ce constantly 1.
- Counters advance only on pix_ce:
  - h_cnt: 0..H_TOTAL-1, wraps to 0.
  - v_cnt: increments when h_cnt wraps; wraps 0 after V_TOTAL-1.
  - On a simultaneous h and v wrap both become 0 on the same pix_ce.
- Request outputs mirror the counters directly: req_col=h_cnt, req_row=v_cnt, req_valid=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
- Raw sync levels:
  - hs_raw is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
  - Output level = POL when active, ~POL otherwise.
- Delay line: {hs,vs,valid,h_cnt,v_cnt} enters a PIPE-stage shift register that shifts only on pix_ce; its last stage drives hsync/vsync/in_screen/col/row. PIPE=0 means the outputs equal the raw values, same registration. col/row hold their value outside the active area and are not forced to 0.
- frame_start: 1 for exactly one clk, on the pix_ce cycle where the pre-advance counters are h_cnt==0, v_cnt==0.
- vblank_start: 1 for one clk on the pix_ce cycle where h_cnt==0, v_cnt==V_ACTIVE.
- frame_cnt: increments by 1 (mod 2^FRAME_W) in the same clk as frame_start, except for the first frame after reset. A first_frame flag, set by reset and cleared at the first frame_start, suppresses that increment.
- Reset values:
  - div_cnt, h_cnt, v_cnt, frame_cnt and all delay stages = 0.
  - hsync=~HS_POL, vsync=~VS_POL; delay stages reset to the inactive sync level.
  - in_screen=0, col=row=0, req_valid=0 (registered), pulses=0, pix_ce=0.
- Reset mid-frame: everything clears immediately (async) and timing restarts at (0,0).
  - The first pix_ce falls at clk index CLK_DIV-1 after clrn rises.
  - frame_start fires on that same cycle.
- Illegal parameters (porch 0, sync 0 or a total overflowing CNT_W) are rejected by elaboration-time checks.

Decomposition:
- Package video_timing_pkg holds the 640x480@60 timing constants and the CNT_W default.
- One natural sub-module, timing_axis_counter: a single-axis counter with wrap output, active/sync decode and parameters ACTIVE/FP/SYNC/BP/POL. It is instantiated twice: horizontal with enable pix_ce; vertical with enable pix_ce&&h_wrap.
- Divider, delay line and pulse/frame logic stay in the top of the block.

Test Plan:
- Defaults, clrn released:
  - pix_ce period is 4 clk.
  - hsync low for 96 pixels (384 clk), starting 656+2 pixels after the line start.
  - Line period 3200 clk; frame period 1,680,000 clk.
- req_col vs col: col equals req_col delayed by exactly PIPE=2 pix_ce events. in_screen rises at col=0,row=0 and falls after col=639.
- CLK_DIV=1, small timing (H 8/1/2/1, V 4/1/1/1):
  - pix_ce constantly 1.
  - Line period 12 clk; frame_start every 84 clk.
  - vblank_start at v_cnt=4, h_cnt=0.
- FRAME_W=2, run 6 frames:
  - frame_cnt sequence 0,1,2,3,0,1.
  - No increment at the first frame_start after reset.
- Assert clrn low mid-line (h_cnt=300, v_cnt=100) for 3 clk:
  - All outputs at reset values within the same clk.
  - frame_start pulse at clk 3 (CLK_DIV-1) after release; timing restarts at (0,0).
- HS_POL=1, VS_POL=1: sync pulses high with identical positions; idle level low in reset and in porches.
